// File: rtl/axi_reg_pkg.sv
// axi_reg_pkg: shared response codes, FSM state types and address decode helpers for axi_reg_bank.
// Revision 1.0 - initial parametrised release.
`default_nettype none

package axi_reg_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

    typedef struct packed {
        logic        oob;
        logic [31:0] idx;
    } reg_idx_t;

    // Below-base or absurdly far addresses are flagged so the 32-bit index never aliases into range.
    function automatic reg_idx_t addr_to_index(input logic [63:0] addr,
                                               input logic [63:0] base,
                                               input int unsigned shift);
        reg_idx_t    res;
        logic [63:0] diff;
        diff    = (addr - base) >> shift;
        res.oob = (addr < base) || (diff[63:32] != 32'd0);
        res.idx = diff[31:0];
        return res;
    endfunction

    // Saturates so a burst starting near the top of the index space cannot wrap back into range.
    function automatic logic [31:0] next_index(input logic [31:0] idx);
        return (&idx) ? idx : idx + 32'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/axi_reg_rd_engine.sv
// axi_reg_rd_engine: AXI4 read channel FSM, beat counter and registered read data for axi_reg_bank.
// Bursts honoured only when AXI_REG_BANK_BURST_EN is defined. Revision 1.0.
`default_nettype none

module axi_reg_rd_engine
    import axi_reg_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    ID_WIDTH   = 4,
    parameter int                    NUM_REGS   = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                           clk,
    input  logic                           areset,
    input  logic [ID_WIDTH-1:0]            arid_i,
    input  logic [ADDR_WIDTH-1:0]          araddr_i,
    input  logic [7:0]                     arlen_i,
    input  logic                           arvalid_i,
    output logic                           arready_o,
    output logic [ID_WIDTH-1:0]            rid_o,
    output logic [DATA_WIDTH-1:0]          rdata_o,
    output logic [1:0]                     rresp_o,
    output logic                           rlast_o,
    output logic                           rvalid_o,
    input  logic                           rready_i,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] regs
);

    localparam int unsigned SHIFT = $clog2(DATA_WIDTH / 8);
    localparam int          IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] reg_arr;
    assign reg_arr = regs;

    rd_state_t   state;
    logic [31:0] idx;
    logic        oob;
    logic [7:0]  len;
    logic [7:0]  beat;
    logic        len_err;

    reg_idx_t             ar_idx;
    logic [7:0]           ar_len_eff;
    logic                 ar_len_err;
    logic [31:0]          load_idx;
    logic                 load_oob;
    logic [7:0]           load_beat;
    logic [7:0]           load_len;
    logic                 load_err;
    logic                 load_ok;
    logic [DATA_WIDTH-1:0] load_data;

    // The "load" values describe the beat that will be presented next, whether it opens a burst or continues one.
    always_comb begin
        ar_idx = addr_to_index(64'(araddr_i), 64'(BASE_ADDR), SHIFT);
`ifdef AXI_REG_BANK_BURST_EN
        ar_len_eff = arlen_i;
        ar_len_err = 1'b0;
`else
        ar_len_eff = 8'd0;
        ar_len_err = (arlen_i != 8'd0);
`endif
        if (state == R_IDLE) begin
            load_idx  = ar_idx.idx;
            load_oob  = ar_idx.oob;
            load_beat = 8'd0;
            load_len  = ar_len_eff;
            load_err  = ar_len_err;
        end else begin
            load_idx  = next_index(idx);
            load_oob  = oob;
            load_beat = beat + 8'd1;
            load_len  = len;
            load_err  = len_err;
        end
        load_ok   = !load_oob && (load_idx < 32'(NUM_REGS));
        load_data = '0;
        if (load_ok) begin
            load_data = reg_arr[load_idx[IDX_W-1:0]];
        end
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state     <= R_IDLE;
            arready_o <= 1'b1;
            rvalid_o  <= 1'b0;
            rlast_o   <= 1'b0;
            rdata_o   <= '0;
            rresp_o   <= RESP_OKAY;
            rid_o     <= '0;
            idx       <= '0;
            oob       <= 1'b0;
            len       <= '0;
            beat      <= '0;
            len_err   <= 1'b0;
        end else begin
            case (state)
                R_IDLE: begin
                    if (arvalid_i) begin
                        arready_o <= 1'b0;
                        rvalid_o  <= 1'b1;
                        rid_o     <= arid_i;
                        idx       <= load_idx;
                        oob       <= load_oob;
                        len       <= load_len;
                        beat      <= load_beat;
                        len_err   <= load_err;
                        rdata_o   <= load_data;
                        rresp_o   <= (load_ok && !load_err) ? RESP_OKAY : RESP_SLVERR;
                        rlast_o   <= (load_beat == load_len);
                        state     <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (rready_i) begin
                        if (beat == len) begin
                            rvalid_o  <= 1'b0;
                            rlast_o   <= 1'b0;
                            arready_o <= 1'b1;
                            state     <= R_IDLE;
                        end else begin
                            idx     <= load_idx;
                            beat    <= load_beat;
                            rdata_o <= load_data;
                            rresp_o <= (load_ok && !load_err) ? RESP_OKAY : RESP_SLVERR;
                            rlast_o <= (load_beat == load_len);
                        end
                    end
                end
                default: state <= R_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/axi_reg_bank.sv
// axi_reg_bank: AXI4 slave register bank with byte strobes, SLVERR responses and per-register write pulses.
// Optional macro AXI_REG_BANK_BURST_EN enables INCR bursts of 1-256 beats. Revision 1.0.
`default_nettype none

module axi_reg_bank
    import axi_reg_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    ID_WIDTH   = 4,
    parameter int                    NUM_REGS   = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                           clk,
    input  logic                           areset,
    input  logic [ID_WIDTH-1:0]            awid_i,
    input  logic [ADDR_WIDTH-1:0]          awaddr_i,
    input  logic [7:0]                     awlen_i,
    input  logic                           awvalid_i,
    output logic                           awready_o,
    input  logic [DATA_WIDTH-1:0]          wdata_i,
    input  logic [DATA_WIDTH/8-1:0]        wstrb_i,
    input  logic                           wlast_i,
    input  logic                           wvalid_i,
    output logic                           wready_o,
    output logic [ID_WIDTH-1:0]            bid_o,
    output logic [1:0]                     bresp_o,
    output logic                           bvalid_o,
    input  logic                           bready_i,
    input  logic [ID_WIDTH-1:0]            arid_i,
    input  logic [ADDR_WIDTH-1:0]          araddr_i,
    input  logic [7:0]                     arlen_i,
    input  logic                           arvalid_i,
    output logic                           arready_o,
    output logic [ID_WIDTH-1:0]            rid_o,
    output logic [DATA_WIDTH-1:0]          rdata_o,
    output logic [1:0]                     rresp_o,
    output logic                           rlast_o,
    output logic                           rvalid_o,
    input  logic                           rready_i,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
    output logic [NUM_REGS-1:0]            reg_wr_pulse_o
);

    localparam int          STRB_W = DATA_WIDTH / 8;
    localparam int unsigned SHIFT  = $clog2(STRB_W);
    localparam int          IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q;
    assign regs_o = regs_q;

    wr_state_t   wstate;
    logic [31:0] widx;
    logic        woob;
    logic [7:0]  wlen;
    logic [7:0]  wbeat;
    logic        werr;

    reg_idx_t   aw_idx;
    logic [7:0] aw_len_eff;
    logic       aw_len_err;
    logic       w_in_range;
    logic       w_final;
    logic       w_last_err;
    logic       w_err_total;

    always_comb begin
        aw_idx     = addr_to_index(64'(awaddr_i), 64'(BASE_ADDR), SHIFT);
        w_in_range = !woob && (widx < 32'(NUM_REGS));
        w_final    = (wbeat == wlen);
`ifdef AXI_REG_BANK_BURST_EN
        aw_len_eff = awlen_i;
        aw_len_err = 1'b0;
        w_last_err = (wlast_i != w_final);
`else
        aw_len_eff = 8'd0;
        aw_len_err = (awlen_i != 8'd0);
        w_last_err = 1'b0;
`endif
        w_err_total = werr | !w_in_range | w_last_err;
    end

`ifndef AXI_REG_BANK_BURST_EN
    // Single-beat mode never looks at wlast; tie it off so the port is still consumed.
    logic unused_wlast;
    assign unused_wlast = wlast_i;
`endif

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            wstate         <= W_IDLE;
            awready_o      <= 1'b1;
            wready_o       <= 1'b0;
            bvalid_o       <= 1'b0;
            bresp_o        <= RESP_OKAY;
            bid_o          <= '0;
            widx           <= '0;
            woob           <= 1'b0;
            wlen           <= '0;
            wbeat          <= '0;
            werr           <= 1'b0;
            reg_wr_pulse_o <= '0;
            regs_q         <= '0;
        end else begin
            reg_wr_pulse_o <= '0;
            case (wstate)
                W_IDLE: begin
                    if (awvalid_i) begin
                        awready_o <= 1'b0;
                        wready_o  <= 1'b1;
                        bid_o     <= awid_i;
                        widx      <= aw_idx.idx;
                        woob      <= aw_idx.oob;
                        wlen      <= aw_len_eff;
                        wbeat     <= 8'd0;
                        werr      <= aw_len_err;
                        wstate    <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (wvalid_i) begin
                        if (w_in_range) begin
                            for (int b = 0; b < STRB_W; b++) begin
                                if (wstrb_i[b]) begin
                                    regs_q[widx[IDX_W-1:0]][b*8 +: 8] <= wdata_i[b*8 +: 8];
                                end
                            end
                            reg_wr_pulse_o[widx[IDX_W-1:0]] <= 1'b1;
                        end
                        widx  <= next_index(widx);
                        wbeat <= wbeat + 8'd1;
                        werr  <= w_err_total;
                        if (w_final) begin
                            wready_o <= 1'b0;
                            bvalid_o <= 1'b1;
                            bresp_o  <= w_err_total ? RESP_SLVERR : RESP_OKAY;
                            wstate   <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (bready_i) begin
                        bvalid_o  <= 1'b0;
                        awready_o <= 1'b1;
                        wstate    <= W_IDLE;
                    end
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end

    axi_reg_rd_engine #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .ID_WIDTH   (ID_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .BASE_ADDR  (BASE_ADDR)
    ) u_rd_engine (
        .clk       (clk),
        .areset    (areset),
        .arid_i    (arid_i),
        .araddr_i  (araddr_i),
        .arlen_i   (arlen_i),
        .arvalid_i (arvalid_i),
        .arready_o (arready_o),
        .rid_o     (rid_o),
        .rdata_o   (rdata_o),
        .rresp_o   (rresp_o),
        .rlast_o   (rlast_o),
        .rvalid_o  (rvalid_o),
        .rready_i  (rready_i),
        .regs      (regs_q)
    );

endmodule

`default_nettype wire
